regfile_wb_ctrl: RTL and testbench

//  Write-back controller for the 2R/1W register file with registered reads.
//  - Arbitrates two write-back requesters onto the single write port: port 0 = ALU/EX, port 1 = load/MEM.
//  - Keeps a per-register busy scoreboard for the issue stage.
//  - Bypasses a write-port/read-port collision, so read data is never stale.
//  - Sits between the EX/MEM stages, the issue logic and the regfile instance.

---
 rtl/regfile_wb_ctrl_pkg.sv | 7 +
 rtl/regfile_wb_ctrl_wb_rr_arb2.sv | 39 +++
 rtl/regfile_wb_ctrl.sv | 103 ++++++++++
 tb/tb_regfile_wb_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared widths and write-back port indices for the register-file write-back controller.
package regfile_wb_ctrl_pkg;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic WB_ALU = 1'b0;
  localparam logic WB_LSU = 1'b1;
endpackage

// File: rtl/regfile_wb_ctrl_wb_rr_arb2.sv
// Two-way write-port arbiter: round-robin on last grant, or fixed priority to the LSU port.
module wb_rr_arb2
  import regfile_wb_ctrl_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic last_q, last_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    last_d = last_q;
    if (req0_i && req1_i) begin
      if (RR_EN && (last_q == WB_LSU)) gnt0_o = 1'b1;
      else                             gnt1_o = 1'b1;
    end else if (req0_i) begin
      gnt0_o = 1'b1;
    end else if (req1_i) begin
      gnt1_o = 1'b1;
    end
    if (gnt0_o)      last_d = WB_ALU;
    else if (gnt1_o) last_d = WB_LSU;
  end

  // Reset to LSU so the ALU wins the first contested cycle.
  always_ff @(posedge clk) begin
    if (rst) last_q <= WB_LSU;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates two requesters onto the regfile write port,
// tracks per-register busy state and patches read data on a same-edge write/read.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic [DATA_W-1:0] rf_rs2_data,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              hit1_q, hit1_d, hit2_q, hit2_d;
  logic [DATA_W-1:0] byp_q;

  wb_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0_i (wb0_valid),
    .req1_i (wb1_valid),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  always_comb begin
    sel_addr = gnt1 ? wb1_addr : wb0_addr;
    sel_data = gnt1 ? wb1_data : wb0_data;
    // x0 writes are accepted but never reach the regfile.
    wen_d    = (gnt0 || gnt1) && (sel_addr != '0);
    waddr_d  = wen_d ? sel_addr : waddr_q;
    wdata_d  = wen_d ? sel_data : wdata_q;

    busy_d = busy_q;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    if (alloc_valid && (alloc_addr != '0)) busy_d[alloc_addr] = 1'b1;

    hit1_d = wen_q && (waddr_q == rs1_addr) && (rs1_addr != '0);
    hit2_d = wen_q && (waddr_q == rs2_addr) && (rs2_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
      byp_q   <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      hit1_q  <= hit1_d;
      hit2_q  <= hit2_d;
      byp_q   <= wdata_q;
    end
  end

  assign wb0_ready = gnt0;
  assign wb1_ready = gnt1;
  assign rs1_busy  = (rs1_addr != '0) && busy_q[rs1_addr];
  assign rs2_busy  = (rs2_addr != '0) && busy_q[rs2_addr];
  assign rf_wen    = wen_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  // The regfile returns pre-write data when read and written on the same edge.
  assign rs1_data  = hit1_q ? byp_q : rf_rs1_data;
  assign rs2_data  = hit2_q ? byp_q : rf_rs2_data;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: vector table plus multi-cycle corner sequences.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid, alloc_valid;
  logic [4:0]  wb0_addr, wb1_addr, alloc_addr, rs1_addr, rs2_addr;
  logic [31:0] wb0_data, wb1_data, rf_rs1_data, rf_rs2_data;

  logic        rr_r0, rr_r1, rr_b1, rr_b2, rr_wen;
  logic [4:0]  rr_waddr;
  logic [31:0] rr_wdata, rr_d1, rr_d2;
  logic        fp_r0, fp_r1, fp_b1, fp_b2, fp_wen;
  logic [4:0]  fp_waddr;
  logic [31:0] fp_wdata, fp_d1, fp_d2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.ADDR_W(5), .DATA_W(32), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(rr_r0),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(rr_r1),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rr_b1), .rs2_busy(rr_b2),
    .rf_wen(rr_wen), .rf_waddr(rr_waddr), .rf_wdata(rr_wdata),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rs1_data(rr_d1), .rs2_data(rr_d2)
  );

  regfile_wb_ctrl #(.ADDR_W(5), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(fp_r0),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(fp_r1),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(fp_b1), .rs2_busy(fp_b2),
    .rf_wen(fp_wen), .rf_waddr(fp_waddr), .rf_wdata(fp_wdata),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rs1_data(fp_d1), .rs2_data(fp_d2)
  );

  typedef struct packed {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        alv;
    logic [4:0]  ala;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        er0;
    logic        er1;
    logic        eb1;
    logic        eb2;
    logic        ewen;
    logic [4:0]  ewaddr;
    logic [31:0] ewdata;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
    alloc_valid = 1'b0; alloc_addr = '0;
    rs1_addr = '0; rs2_addr = '0;
    rf_rs1_data = '0; rf_rs2_data = '0;
  endtask

  initial begin
    //           v0 a0  d0            v1 a1  d1            alv ala rs1 rs2 er0 er1 eb1 eb2 wen wa  wdata
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33,      1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[7]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,      1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11};
    vecs[8]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,      1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22};
    vecs[9]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,      1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11};
    vecs[10] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,      1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_wen", {31'd0, rr_wen}, 32'd0);
    chk("reset_waddr", {27'd0, rr_waddr}, 32'd0);
    chk("reset_wdata", rr_wdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      wb0_valid = vecs[i].v0; wb0_addr = vecs[i].a0; wb0_data = vecs[i].d0;
      wb1_valid = vecs[i].v1; wb1_addr = vecs[i].a1; wb1_data = vecs[i].d1;
      alloc_valid = vecs[i].alv; alloc_addr = vecs[i].ala;
      rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
      #1;
      chk($sformatf("v%0d_ready0", i), {31'd0, rr_r0}, {31'd0, vecs[i].er0});
      chk($sformatf("v%0d_ready1", i), {31'd0, rr_r1}, {31'd0, vecs[i].er1});
      chk($sformatf("v%0d_busy1", i), {31'd0, rr_b1}, {31'd0, vecs[i].eb1});
      chk($sformatf("v%0d_busy2", i), {31'd0, rr_b2}, {31'd0, vecs[i].eb2});
      chk($sformatf("v%0d_fp_ready0", i), {31'd0, fp_r0}, {31'd0, vecs[i].v0 && !vecs[i].v1});
      chk($sformatf("v%0d_fp_ready1", i), {31'd0, fp_r1}, {31'd0, vecs[i].v1});
      tick();
      chk($sformatf("v%0d_wen", i), {31'd0, rr_wen}, {31'd0, vecs[i].ewen});
      if (vecs[i].ewen) begin
        chk($sformatf("v%0d_waddr", i), {27'd0, rr_waddr}, {27'd0, vecs[i].ewaddr});
        chk($sformatf("v%0d_wdata", i), rr_wdata, vecs[i].ewdata);
      end
    end

    // Bypass: write x7 lands on the same edge as a read of x7; regfile returns stale data.
    idle();
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1234;
    tick();
    idle();
    rs1_addr = 5'd7; rs2_addr = 5'd0;
    tick();
    rf_rs1_data = 32'hAAAA; rf_rs2_data = 32'h0;
    #1;
    chk("byp_rs1_hit", rr_d1, 32'h1234);
    chk("byp_rs2_x0", rr_d2, 32'h0);
    tick();
    rf_rs1_data = 32'h5555;
    #1;
    chk("byp_rs1_no_hit", rr_d1, 32'h5555);

    idle();
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1234;
    tick();
    idle();
    rs1_addr = 5'd0;
    tick();
    rf_rs1_data = 32'h0;
    #1;
    chk("byp_x0_read", rr_d1, 32'h0);

    // Alloc of x3 on the same edge its write-back clears it: stays busy.
    idle();
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h3;
    tick();
    idle();
    alloc_valid = 1'b1; alloc_addr = 5'd3;
    tick();
    idle();
    rs1_addr = 5'd3;
    #1;
    chk("sb_set_wins", {31'd0, rr_b1}, 32'd1);

    // Reset mid-traffic: pending write and busy bits dropped.
    idle();
    alloc_valid = 1'b1; alloc_addr = 5'd4;
    tick();
    idle();
    rs2_addr = 5'd4;
    #1;
    chk("pre_rst_busy4", {31'd0, rr_b2}, 32'd1);
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h99;
    rst = 1'b1;
    tick();
    chk("rst1_wen", {31'd0, rr_wen}, 32'd0);
    tick();
    chk("rst2_wen", {31'd0, rr_wen}, 32'd0);
    rst = 1'b0;
    idle();
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    #1;
    chk("post_rst_busy3", {31'd0, rr_b1}, 32'd0);
    chk("post_rst_busy4", {31'd0, rr_b2}, 32'd0);
    chk("post_rst_waddr", {27'd0, rr_waddr}, 32'd0);

    // First contested cycle after reset: ALU wins under round-robin; LSU always wins fixed.
    wb0_valid = 1'b1; wb0_addr = 5'd10; wb0_data = 32'hA0;
    wb1_valid = 1'b1; wb1_addr = 5'd11; wb1_data = 32'hB0;
    #1;
    chk("rst_rr_first_gnt0", {31'd0, rr_r0}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("fp_stall%0d_r0", c), {31'd0, fp_r0}, 32'd0);
      chk($sformatf("fp_stall%0d_r1", c), {31'd0, fp_r1}, 32'd1);
      tick();
      chk($sformatf("fp_stall%0d_waddr", c), {27'd0, fp_waddr}, 32'd11);
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
